signal_measure: RTL and testbench
=================================

SIGNAL_MEASURE -- requirements
Module: signal_measure

Interface
REQ-001 The parameter GATE_CYCLES SHALL default to 65_000_000 and set the measurement window length in clk cycles (1 s at 65 MHz).
REQ-002 The parameter HYST SHALL default to 16 and set the Schmitt hysteresis half-width in ADC LSBs.
REQ-003 The parameter FRQ_W SHALL default to 20 and set the edge-count output width.
REQ-004 Port clk SHALL be an input, 1 bit wide, and serve as the sole clock; all logic is on its rising edge.
REQ-005 Port rst SHALL be an input, 1 bit wide, synchronous, active-low reset.
REQ-006 Port sample SHALL be an input, 12 bits wide, carrying the ADC code (data_adc), already in the clk domain.
REQ-007 Port sample_valid SHALL be an input, 1 bit wide, a one-cycle strobe qualifying sample.
REQ-008 Port p2p SHALL be an output, 12 bits wide, giving the peak-to-peak of the last completed window.
REQ-009 Port frq SHALL be an output, FRQ_W bits wide, giving the rising-crossing count of the last completed window (Hz when GATE_CYCLES = 1 s).
REQ-010 Port frq_ovf SHALL be an output, 1 bit wide, set when the last window's count saturated.
REQ-011 Port meas_valid SHALL be an output, 1 bit wide, a one-cycle pulse when p2p, frq and frq_ovf update.

Function
REQ-012 Gate counter SHALL count 0..GATE_CYCLES-1 continuously and wrap to 0; the window ends on the cycle the count equals GATE_CYCLES-1.
REQ-013 A sample_valid on the window's last cycle SHALL belong to the ending window.
REQ-014 The first valid sample of a window SHALL load both the window minimum and maximum; later samples update them with unsigned compare.
REQ-015 On the cycle after window end, p2p SHALL load max-min, or 0 if the window had no valid sample.
REQ-016 On that same cycle, frq SHALL load the edge count and frq_ovf the saturation flag, and meas_valid SHALL pulse high for exactly one cycle.
REQ-017 Outputs SHALL hold between updates.
REQ-018 The crossing threshold thr for window N SHALL be (min+max)>>1 of window N-1, computed with a 13-bit sum; it is 2048 after reset and unchanged after an empty window.
REQ-019 Upper level SHALL be min(thr+HYST, 4095) and lower level max(thr-HYST, 0), computed without wrap.
REQ-020 The Schmitt FSM SHALL have states UNKNOWN, LOW and HIGH.
REQ-021 In UNKNOWN, the first valid sample SHALL move the FSM to HIGH if sample >= upper, else to LOW, without counting an edge.
REQ-022 In LOW, a valid sample >= upper SHALL move the FSM to HIGH and increment the edge count.
REQ-023 In HIGH, a valid sample <= lower SHALL move the FSM to LOW.
REQ-024 Any other valid sample SHALL hold the FSM state.
REQ-025 FSM state SHALL persist across window boundaries.
REQ-026 The edge count SHALL clear at window start.
REQ-027 An edge occurring on the window's last cycle SHALL count in the ending window.
REQ-028 The edge count SHALL saturate at 2^FRQ_W-1, with a sticky per-window ovf flag.
REQ-029 Threshold update and window-statistics clear SHALL occur on the same cycle as the result latch; a sample arriving on that cycle SHALL count in the new window and use the new threshold.

Reset
REQ-030 When rst=0 at a clk edge, the following SHALL reset:
- p2p=0, frq=0, frq_ovf=0, meas_valid=0
- gate counter=0, edge count=0
- thr=2048, FSM=UNKNOWN
- window marked empty
REQ-031 Reset asserted mid-window SHALL discard that window, with no meas_valid pulse.
REQ-032 The first meas_valid after reset release SHALL occur GATE_CYCLES+1 cycles after the first clk edge with rst=1.

Structure
REQ-033 ADC_W=12 and the Schmitt state enum (UNKNOWN/LOW/HIGH) SHALL reside in the shared package osc_pkg.
REQ-034 The Schmitt detector (state, levels, edge pulse) SHALL be the sub-module hyst_edge_det; window statistics and the gate counter stay in signal_measure.
REQ-035 The block SHALL be instantiated in the top level with sample=data_adc, and p2p/frq wired to font_gen.

Verification (GATE_CYCLES=1000, HYST=16)
REQ-036 Scenario: square wave 1000/3000, sample_valid every cycle, period 100 cycles -> second window gives p2p=2000, frq=10, frq_ovf=0, meas_valid width 1.
REQ-037 Scenario: no sample_valid for a full window -> p2p=0, frq=0; thr unchanged (2048).
REQ-038 Scenario: noise toggling 2040/2056 around thr=2048 -> frq=0 (hysteresis holds).
REQ-039 Scenario: FRQ_W=4, 20 edges in a window -> frq=15, frq_ovf=1; next clean window with 3 edges -> frq=3, frq_ovf=0.
REQ-040 Scenario: rst=0 at gate count 500 -> outputs 0, no meas_valid; first meas_valid 1001 cycles after release.
REQ-041 Scenario: rising crossing injected on gate count 999 -> counted in the ending window; crossing at count 0 of the next window -> counted in the new window.

Source files
------------

// File: rtl/osc_pkg.sv
// Shared definitions for the oscilloscope signal path: ADC width,
// Schmitt detector state encoding and threshold-level helpers.
package osc_pkg;

  localparam int ADC_W = 12;
  localparam int unsigned ADC_MAX = (1 << ADC_W) - 1;
  localparam logic [ADC_W-1:0] THR_RESET = ADC_W'(2048);

  typedef enum logic [1:0] {
    UNKNOWN = 2'd0,
    LOW     = 2'd1,
    HIGH    = 2'd2
  } schmitt_state_t;

  // Upper Schmitt level, clamped at full scale instead of wrapping.
  function automatic logic [ADC_W-1:0] level_upper(input logic [ADC_W-1:0] thr,
                                                   input int unsigned hyst);
    int unsigned sum;
    sum = 32'(thr) + hyst;
    return (sum > ADC_MAX) ? ADC_W'(ADC_MAX) : ADC_W'(sum);
  endfunction

  // Lower Schmitt level, clamped at zero instead of wrapping.
  function automatic logic [ADC_W-1:0] level_lower(input logic [ADC_W-1:0] thr,
                                                   input int unsigned hyst);
    return (32'(thr) > hyst) ? ADC_W'(32'(thr) - hyst) : '0;
  endfunction

  // Midpoint of a min/max pair using a sum one bit wider than the ADC code.
  function automatic logic [ADC_W-1:0] midpoint(input logic [ADC_W-1:0] lo,
                                                input logic [ADC_W-1:0] hi);
    logic [ADC_W:0] sum;
    sum = {1'b0, lo} + {1'b0, hi};
    return sum[ADC_W:1];
  endfunction

endpackage

// File: rtl/hyst_edge_det.sv
// Schmitt-trigger rising-crossing detector around a supplied threshold.
// edge_pulse is combinational so the crossing counts on the sample's own cycle.
module hyst_edge_det
  import osc_pkg::*;
#(
  parameter int unsigned HYST = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [ADC_W-1:0] sample,
  input  logic             sample_valid,
  input  logic [ADC_W-1:0] thr,
  output logic             edge_pulse
);

  schmitt_state_t   state_reg;
  schmitt_state_t   state_next;
  logic [ADC_W-1:0] upper;
  logic [ADC_W-1:0] lower;

  assign upper = level_upper(thr, HYST);
  assign lower = level_lower(thr, HYST);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg <= UNKNOWN;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    edge_pulse = 1'b0;
    if (sample_valid) begin
      case (state_reg)
        // First observation only establishes the level; it is never an edge.
        UNKNOWN: state_next = (sample >= upper) ? HIGH : LOW;
        LOW: begin
          if (sample >= upper) begin
            state_next = HIGH;
            edge_pulse = 1'b1;
          end
        end
        HIGH: begin
          if (sample <= lower) begin
            state_next = LOW;
          end
        end
        default: state_next = UNKNOWN;
      endcase
    end
  end

endmodule

// File: rtl/signal_measure.sv
// Gated measurement of peak-to-peak amplitude and rising-crossing count
// of an ADC stream; results are published once per gate window.
module signal_measure
  import osc_pkg::*;
#(
  parameter int unsigned GATE_CYCLES = 65_000_000,
  parameter int unsigned HYST        = 16,
  parameter int unsigned FRQ_W       = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [ADC_W-1:0] sample,
  input  logic             sample_valid,
  output logic [ADC_W-1:0] p2p,
  output logic [FRQ_W-1:0] frq,
  output logic             frq_ovf,
  output logic             meas_valid
);

  localparam int unsigned GATE_W = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
  localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);
  localparam logic [FRQ_W-1:0]  FRQ_MAX   = '1;

  logic [GATE_W-1:0] gate_reg, gate_next;
  logic              win_done_reg, win_done_next;
  logic              has_sample_reg, has_sample_next;
  logic [ADC_W-1:0]  min_reg, min_next;
  logic [ADC_W-1:0]  max_reg, max_next;
  logic [ADC_W-1:0]  thr_reg, thr_next;
  logic [FRQ_W-1:0]  cnt_reg, cnt_next;
  logic              ovf_reg, ovf_next;
  logic [ADC_W-1:0]  p2p_reg, p2p_next;
  logic [FRQ_W-1:0]  frq_reg, frq_next;
  logic              frq_ovf_reg, frq_ovf_next;
  logic              meas_valid_reg, meas_valid_next;
  logic [ADC_W-1:0]  thr_active;
  logic              rise;

  // win_done_reg marks the first cycle of a new window: results latch,
  // statistics restart and the new threshold is already in force.
  assign thr_active = (win_done_reg && has_sample_reg) ? midpoint(min_reg, max_reg) : thr_reg;

  hyst_edge_det #(
    .HYST(HYST)
  ) u_edge_det (
    .clk         (clk),
    .rst         (rst),
    .sample      (sample),
    .sample_valid(sample_valid),
    .thr         (thr_active),
    .edge_pulse  (rise)
  );

  always_comb begin
    gate_next     = (gate_reg == GATE_LAST) ? '0 : gate_reg + 1'b1;
    win_done_next = (gate_reg == GATE_LAST);
    thr_next      = thr_active;
  end

  always_comb begin
    has_sample_next = has_sample_reg;
    min_next        = min_reg;
    max_next        = max_reg;
    if (win_done_reg) begin
      has_sample_next = 1'b0;
    end
    if (sample_valid) begin
      if (!has_sample_next) begin
        min_next = sample;
        max_next = sample;
      end else begin
        if (sample < min_reg) min_next = sample;
        if (sample > max_reg) max_next = sample;
      end
      has_sample_next = 1'b1;
    end
  end

  always_comb begin
    cnt_next = cnt_reg;
    ovf_next = ovf_reg;
    if (win_done_reg) begin
      cnt_next = '0;
      ovf_next = 1'b0;
    end
    if (rise) begin
      if (cnt_next == FRQ_MAX) begin
        ovf_next = 1'b1;
      end else begin
        cnt_next = cnt_next + 1'b1;
      end
    end
  end

  always_comb begin
    p2p_next        = p2p_reg;
    frq_next        = frq_reg;
    frq_ovf_next    = frq_ovf_reg;
    meas_valid_next = win_done_reg;
    if (win_done_reg) begin
      p2p_next     = has_sample_reg ? (max_reg - min_reg) : '0;
      frq_next     = cnt_reg;
      frq_ovf_next = ovf_reg;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      gate_reg       <= '0;
      win_done_reg   <= 1'b0;
      has_sample_reg <= 1'b0;
      min_reg        <= '0;
      max_reg        <= '0;
      thr_reg        <= THR_RESET;
      cnt_reg        <= '0;
      ovf_reg        <= 1'b0;
      p2p_reg        <= '0;
      frq_reg        <= '0;
      frq_ovf_reg    <= 1'b0;
      meas_valid_reg <= 1'b0;
    end else begin
      gate_reg       <= gate_next;
      win_done_reg   <= win_done_next;
      has_sample_reg <= has_sample_next;
      min_reg        <= min_next;
      max_reg        <= max_next;
      thr_reg        <= thr_next;
      cnt_reg        <= cnt_next;
      ovf_reg        <= ovf_next;
      p2p_reg        <= p2p_next;
      frq_reg        <= frq_next;
      frq_ovf_reg    <= frq_ovf_next;
      meas_valid_reg <= meas_valid_next;
    end
  end

  assign p2p        = p2p_reg;
  assign frq        = frq_reg;
  assign frq_ovf    = frq_ovf_reg;
  assign meas_valid = meas_valid_reg;

endmodule

// File: tb/tb_signal_measure.sv
// Bench for signal_measure: two instances (FRQ_W=20 and FRQ_W=4) share stimulus
// and are compared every cycle against a window-level behavioural model.
module tb_signal_measure;

  localparam int G = 1000;
  localparam int H = 16;

  localparam int M_IDLE    = 0;
  localparam int M_SQ      = 1;
  localparam int M_NOISE   = 2;
  localparam int M_PROBE   = 3;
  localparam int M_FAST    = 4;
  localparam int M_THREE   = 5;
  localparam int M_EDGE999 = 6;
  localparam int M_PREHIGH = 7;
  localparam int M_EDGE0   = 8;
  localparam int M_RAND    = 9;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [11:0] sample = '0;
  logic        sample_valid = 1'b0;

  logic [11:0] p2p_a, p2p_b;
  logic [19:0] frq_a;
  logic [3:0]  frq_b;
  logic        ovf_a, ovf_b, mv_a, mv_b;

  always #5 clk = ~clk;

  signal_measure #(.GATE_CYCLES(G), .HYST(H), .FRQ_W(20)) dut (
    .clk(clk), .rst(rst), .sample(sample), .sample_valid(sample_valid),
    .p2p(p2p_a), .frq(frq_a), .frq_ovf(ovf_a), .meas_valid(mv_a)
  );

  signal_measure #(.GATE_CYCLES(G), .HYST(H), .FRQ_W(4)) dut4 (
    .clk(clk), .rst(rst), .sample(sample), .sample_valid(sample_valid),
    .p2p(p2p_b), .frq(frq_b), .frq_ovf(ovf_b), .meas_valid(mv_b)
  );

  int checks = 0;
  int errors = 0;

  // Behavioural model state: window position, sample list, crossing count.
  int m_pos = 0;
  bit m_done = 0;
  int m_thr = 2048;
  int m_st = 0;
  int m_cnt = 0;
  int m_q[$];
  int e_p2p = 0;
  int e_cnt = 0;
  bit e_mv = 0;

  int rel_cycles = 0;
  int first_mv = -1;
  bit seen_mv = 0;
  int win_no = 0;

  int cap_p2p = -1, cap_frq = -1, cap_ovf = -1, cap_frq4 = -1, cap_ovf4 = -1;
  int r_period = 50, r_hi = 3000, r_lo = 1000, r_noise = 20;

  function automatic int sat(input int c, input int w);
    int m;
    m = (1 << w) - 1;
    return (c > m) ? m : c;
  endfunction

  task automatic model_edge();
    int mn, mx, up, lo, s;
    if (!rst) begin
      m_pos = 0; m_done = 0; m_thr = 2048; m_st = 0; m_cnt = 0;
      m_q.delete();
      e_p2p = 0; e_cnt = 0; e_mv = 0;
    end else begin
      e_mv = m_done;
      if (m_done) begin
        if (m_q.size() == 0) begin
          e_p2p = 0;
        end else begin
          mn = 4096; mx = -1;
          foreach (m_q[k]) begin
            if (m_q[k] < mn) mn = m_q[k];
            if (m_q[k] > mx) mx = m_q[k];
          end
          e_p2p = mx - mn;
          m_thr = (mn + mx) / 2;
        end
        e_cnt = m_cnt;
        m_cnt = 0;
        m_q.delete();
      end
      if (sample_valid) begin
        s  = int'(sample);
        up = (m_thr + H > 4095) ? 4095 : m_thr + H;
        lo = (m_thr - H < 0) ? 0 : m_thr - H;
        m_q.push_back(s);
        if (m_st == 0) m_st = (s >= up) ? 2 : 1;
        else if (m_st == 1 && s >= up) begin m_st = 2; m_cnt++; end
        else if (m_st == 2 && s <= lo) m_st = 1;
      end
      m_done = (m_pos == G - 1);
      m_pos = (m_pos + 1) % G;
    end
  endtask

  task automatic check_cycle();
    logic [19:0] ef20;
    logic [3:0]  ef4;
    logic        eo20, eo4;
    ef20 = 20'(sat(e_cnt, 20));
    eo20 = (e_cnt > sat(e_cnt, 20));
    ef4  = 4'(sat(e_cnt, 4));
    eo4  = (e_cnt > sat(e_cnt, 4));
    checks++;
    if (mv_a !== e_mv) begin
      errors++;
      $display("FAIL meas_valid_w20 @%0t: got %b expected %b", $time, mv_a, e_mv);
    end
    checks++;
    if (mv_b !== e_mv) begin
      errors++;
      $display("FAIL meas_valid_w4 @%0t: got %b expected %b", $time, mv_b, e_mv);
    end
    checks++;
    if (p2p_a !== 12'(e_p2p) || frq_a !== ef20 || ovf_a !== eo20) begin
      errors++;
      $display("FAIL outputs_w20 @%0t: got p2p=%0d frq=%0d ovf=%b expected p2p=%0d frq=%0d ovf=%b",
               $time, p2p_a, frq_a, ovf_a, e_p2p, ef20, eo20);
    end
    checks++;
    if (p2p_b !== 12'(e_p2p) || frq_b !== ef4 || ovf_b !== eo4) begin
      errors++;
      $display("FAIL outputs_w4 @%0t: got p2p=%0d frq=%0d ovf=%b expected p2p=%0d frq=%0d ovf=%b",
               $time, p2p_b, frq_b, ovf_b, e_p2p, ef4, eo4);
    end
    if (mv_a === 1'b1) begin
      cap_p2p = int'(p2p_a); cap_frq = int'(frq_a); cap_ovf = int'(ovf_a);
      win_no++;
      $display("window %0d: p2p=%0d frq=%0d ovf=%0d frq4=%0d ovf4=%0d",
               win_no, p2p_a, frq_a, ovf_a, frq_b, ovf_b);
    end
    if (mv_b === 1'b1) begin
      cap_frq4 = int'(frq_b); cap_ovf4 = int'(ovf_b);
    end
    if (rst && mv_a === 1'b1 && !seen_mv) begin
      first_mv = rel_cycles;
      seen_mv = 1;
    end
  endtask

  task automatic step(input logic v, input logic [11:0] s);
    @(negedge clk);
    sample_valid = v;
    sample = s;
    @(posedge clk);
    model_edge();
    if (rst) rel_cycles++;
    else begin rel_cycles = 0; seen_mv = 0; first_mv = -1; end
    #1;
    check_cycle();
  endtask

  task automatic pat(input int mode, input int i, output logic v, output logic [11:0] s);
    int base;
    v = 1'b1;
    s = '0;
    case (mode)
      M_IDLE:    v = 1'b0;
      M_SQ:      s = ((i % 100) < 50) ? 12'd1000 : 12'd3000;
      M_NOISE:   s = ((i % 2) == 0) ? 12'd2040 : 12'd2056;
      M_PROBE:   s = (((i / 10) % 2) == 0) ? 12'd2031 : 12'd2064;
      M_FAST:    s = ((i % 50) < 25) ? 12'd1000 : 12'd3000;
      M_THREE:   s = ((i % 300) < 150) ? 12'd1000 : 12'd3000;
      M_EDGE999: s = (i == G - 1) ? 12'd3000 : 12'd1000;
      M_PREHIGH: s = (i == G - 1) ? 12'd1000 : 12'd3000;
      M_EDGE0:   s = 12'd3000;
      default: begin
        v = ($urandom_range(0, 3) != 0);
        base = (((i / r_period) % 2) == 0) ? r_lo : r_hi;
        s = 12'(base + int'($urandom_range(0, r_noise)));
      end
    endcase
  endtask

  task automatic run_window(input int mode);
    logic v;
    logic [11:0] s;
    for (int i = 0; i < G; i++) begin
      pat(mode, i, v, s);
      step(v, s);
    end
  endtask

  task automatic do_reset(input int n);
    rst = 1'b0;
    repeat (n) step(1'b0, 12'd0);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    do_reset(4);
    checks++;
    if (p2p_a !== 12'd0 || frq_a !== 20'd0 || ovf_a !== 1'b0 || mv_a !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: got p2p=%0d frq=%0d ovf=%b mv=%b expected all zero",
               p2p_a, frq_a, ovf_a, mv_a);
    end
  endtask

  task automatic test_square();
    run_window(M_SQ);
    run_window(M_SQ);
    run_window(M_IDLE);
    checks++;
    if (first_mv !== G + 1) begin
      errors++;
      $display("FAIL first_meas_latency: got %0d expected %0d", first_mv, G + 1);
    end
    checks++;
    if (cap_p2p !== 2000 || cap_frq !== 10 || cap_ovf !== 0) begin
      errors++;
      $display("FAIL square_window: got p2p=%0d frq=%0d ovf=%0d expected p2p=2000 frq=10 ovf=0",
               cap_p2p, cap_frq, cap_ovf);
    end
  endtask

  task automatic test_empty();
    do_reset(2);
    run_window(M_IDLE);
    run_window(M_PROBE);
    checks++;
    if (cap_p2p !== 0 || cap_frq !== 0) begin
      errors++;
      $display("FAIL empty_window: got p2p=%0d frq=%0d expected 0 0", cap_p2p, cap_frq);
    end
    run_window(M_IDLE);
    checks++;
    if (cap_frq !== 50 || cap_p2p !== 33) begin
      errors++;
      $display("FAIL thr_after_empty: got frq=%0d p2p=%0d expected frq=50 p2p=33", cap_frq, cap_p2p);
    end
  endtask

  task automatic test_noise();
    do_reset(2);
    run_window(M_NOISE);
    run_window(M_NOISE);
    run_window(M_IDLE);
    checks++;
    if (cap_frq !== 0 || cap_p2p !== 16) begin
      errors++;
      $display("FAIL noise_hysteresis: got frq=%0d p2p=%0d expected frq=0 p2p=16", cap_frq, cap_p2p);
    end
  endtask

  task automatic test_saturate();
    run_window(M_FAST);
    run_window(M_THREE);
    checks++;
    if (cap_frq4 !== 15 || cap_ovf4 !== 1 || cap_frq !== 20 || cap_ovf !== 0) begin
      errors++;
      $display("FAIL saturate_window: got frq4=%0d ovf4=%0d frq20=%0d ovf20=%0d expected 15 1 20 0",
               cap_frq4, cap_ovf4, cap_frq, cap_ovf);
    end
    run_window(M_IDLE);
    checks++;
    if (cap_frq4 !== 3 || cap_ovf4 !== 0) begin
      errors++;
      $display("FAIL saturate_recover: got frq4=%0d ovf4=%0d expected 3 0", cap_frq4, cap_ovf4);
    end
  endtask

  task automatic test_gate_edges();
    run_window(M_EDGE999);
    run_window(M_PREHIGH);
    checks++;
    if (cap_frq !== 1) begin
      errors++;
      $display("FAIL edge_last_cycle: got frq=%0d expected 1", cap_frq);
    end
    run_window(M_EDGE0);
    checks++;
    if (cap_frq !== 0) begin
      errors++;
      $display("FAIL edge_prep_window: got frq=%0d expected 0", cap_frq);
    end
    run_window(M_IDLE);
    checks++;
    if (cap_frq !== 1) begin
      errors++;
      $display("FAIL edge_first_cycle: got frq=%0d expected 1", cap_frq);
    end
  endtask

  task automatic test_reset_mid();
    logic v;
    logic [11:0] s;
    for (int i = 0; i < G / 2; i++) begin
      pat(M_SQ, i, v, s);
      step(v, s);
    end
    do_reset(3);
    checks++;
    if (p2p_a !== 12'd0 || frq_a !== 20'd0 || ovf_a !== 1'b0 || mv_a !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_window: got p2p=%0d frq=%0d ovf=%b mv=%b expected all zero",
               p2p_a, frq_a, ovf_a, mv_a);
    end
    for (int i = 0; i < G + 1; i++) begin
      pat(M_SQ, i, v, s);
      step(v, s);
    end
    checks++;
    if (first_mv !== G + 1) begin
      errors++;
      $display("FAIL reset_mid_latency: got %0d expected %0d", first_mv, G + 1);
    end
  endtask

  task automatic test_random();
    do_reset(2);
    for (int w = 0; w < 4; w++) begin
      r_period = int'($urandom_range(8, 200));
      r_hi     = int'($urandom_range(2200, 4000));
      r_lo     = int'($urandom_range(0, 1900));
      r_noise  = int'($urandom_range(0, 40));
      run_window(M_RAND);
    end
    run_window(M_IDLE);
  endtask

  initial begin
    test_reset();
    test_square();
    test_empty();
    test_noise();
    test_saturate();
    test_gate_edges();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
